// File: rtl/multiplier_slave_pkg.sv
// Shared constants for the Booth multiplier bus front end: register map,
// front-end FSM encoding and the core's state codes.
package multiplier_slave_pkg;

  localparam logic [3:0] ADDR_A_LO    = 4'h0;
  localparam logic [3:0] ADDR_A_HI    = 4'h1;
  localparam logic [3:0] ADDR_B_LO    = 4'h2;
  localparam logic [3:0] ADDR_B_HI    = 4'h3;
  localparam logic [3:0] ADDR_START   = 4'h4;
  localparam logic [3:0] ADDR_CLEAR   = 4'h5;
  localparam logic [3:0] ADDR_STATUS  = 4'h6;
  localparam logic [3:0] ADDR_INTR_EN = 4'h7;
  localparam logic [3:0] ADDR_RESULT0 = 4'h8;
  localparam logic [3:0] ADDR_RESULT1 = 4'h9;
  localparam logic [3:0] ADDR_RESULT2 = 4'hA;
  localparam logic [3:0] ADDR_RESULT3 = 4'hB;

  localparam logic [1:0] CORE_INIT = 2'b00;
  localparam logic [1:0] CORE_DONE = 2'b01;
  localparam logic [1:0] CORE_LOAD = 2'b10;
  localparam logic [1:0] CORE_EXEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/multiplier_slave_if.sv
// Single-cycle register bus between the CPU (master) and the multiplier
// front end (slave).
interface multiplier_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) ();
  logic              S_sel;
  logic              S_wr;
  logic [ADDR_W-1:0] S_addr;
  logic [DATA_W-1:0] S_din;
  logic [DATA_W-1:0] S_dout;

  modport master (output S_sel, output S_wr, output S_addr, output S_din, input S_dout);
  modport slave  (input S_sel, input S_wr, input S_addr, input S_din, output S_dout);
endinterface

// File: rtl/multiplier_slave.sv
// Register front end for the 64x64 signed Booth multiplier core.
// Optional interrupt enable register and o_intr output: define MUL_SLAVE_INTR_EN.
module multiplier_slave
  import multiplier_slave_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int OPND_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  multiplier_slave_if.slave     bus,
  output logic                  o_intr,
  output logic                  op_start,
  output logic                  op_clear,
  output logic [OPND_W-1:0]     multiplicand,
  output logic [OPND_W-1:0]     multiplier,
  input  logic [1:0]            core_state,
  input  logic [2*OPND_W-1:0]   core_result
);

  state_t                r_state;
  state_t                w_state_next;
  logic [OPND_W-1:0]     r_a;
  logic [OPND_W-1:0]     r_b;
  logic [2*OPND_W-1:0]   r_result;
  logic                  r_done;
  logic                  r_op_start;
  logic                  r_op_clear;
  logic [DATA_W-1:0]     r_dout;

  logic [3:0]            w_addr;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_start_req;
  logic                  w_clear_req;
  logic                  w_busy;
  logic                  w_core_done;
  logic                  w_done_next;
  logic                  w_latch_result;
  logic                  w_intr_en;
  logic [DATA_W-1:0]     w_rdata;

  assign w_addr      = bus.S_addr[3:0];
  assign w_wr        = bus.S_sel & bus.S_wr;
  assign w_rd        = bus.S_sel & ~bus.S_wr;
  assign w_start_req = w_wr && (w_addr == ADDR_START) && bus.S_din[0];
  assign w_clear_req = w_wr && (w_addr == ADDR_CLEAR) && bus.S_din[0];
  assign w_busy      = (r_state == ST_START) || (r_state == ST_BUSY);
  assign w_core_done = (core_state == CORE_DONE);

  // FSM next state plus the done/result side effects of each transition
  always_comb begin
    w_state_next   = r_state;
    w_done_next    = r_done;
    w_latch_result = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_req) w_state_next = ST_START;
      end
      ST_START: begin
        w_state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_core_done) begin
          w_state_next   = ST_DONE;
          w_done_next    = 1'b1;
          w_latch_result = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_start_req) begin
          w_state_next = ST_START;
          w_done_next  = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // CLEAR overrides everything, including a completion in the same cycle
    if (w_clear_req) begin
      w_state_next   = ST_IDLE;
      w_done_next    = 1'b0;
      w_latch_result = 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_A_LO:    w_rdata = r_a[0 +: DATA_W];
      ADDR_A_HI:    w_rdata = r_a[DATA_W +: DATA_W];
      ADDR_B_LO:    w_rdata = r_b[0 +: DATA_W];
      ADDR_B_HI:    w_rdata = r_b[DATA_W +: DATA_W];
      ADDR_STATUS:  w_rdata[1:0] = {r_done, w_busy};
      ADDR_INTR_EN: w_rdata[0] = w_intr_en;
      ADDR_RESULT0: w_rdata = r_result[0*DATA_W +: DATA_W];
      ADDR_RESULT1: w_rdata = r_result[1*DATA_W +: DATA_W];
      ADDR_RESULT2: w_rdata = r_result[2*DATA_W +: DATA_W];
      ADDR_RESULT3: w_rdata = r_result[3*DATA_W +: DATA_W];
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_op_start <= 1'b0;
      r_op_clear <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= w_done_next;
      r_op_start <= (w_state_next == ST_START);
      r_op_clear <= w_clear_req;

      if (w_clear_req)
        r_result <= '0;
      else if (w_latch_result)
        r_result <= core_result;

      // Operands stay frozen while the core is consuming them
      if (w_wr && !w_busy) begin
        case (w_addr)
          ADDR_A_LO: r_a[0 +: DATA_W]      <= bus.S_din;
          ADDR_A_HI: r_a[DATA_W +: DATA_W] <= bus.S_din;
          ADDR_B_LO: r_b[0 +: DATA_W]      <= bus.S_din;
          ADDR_B_HI: r_b[DATA_W +: DATA_W] <= bus.S_din;
          default: ;
        endcase
      end

      if (w_rd) r_dout <= w_rdata;
    end
  end

`ifdef MUL_SLAVE_INTR_EN
  logic r_intr_en;
  logic r_intr;
  logic w_intr_en_next;

  assign w_intr_en_next = (w_wr && (w_addr == ADDR_INTR_EN)) ? bus.S_din[0] : r_intr_en;

  // Interrupt follows the next-cycle done flag so it drops together with done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_intr_en <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_intr_en <= w_intr_en_next;
      r_intr    <= w_done_next & w_intr_en_next;
    end
  end

  assign w_intr_en = r_intr_en;
  assign o_intr    = r_intr;
`else
  assign w_intr_en = 1'b0;
  assign o_intr    = 1'b0;
`endif

  assign bus.S_dout   = r_dout;
  assign op_start     = r_op_start;
  assign op_clear     = r_op_clear;
  assign multiplicand = r_a;
  assign multiplier   = r_b;

endmodule

// File: tb/tb_multiplier_slave.sv
// Randomized self-checking bench for multiplier_slave with a behavioural core stub
// and a register-level reference model.
module tb_multiplier_slave;
  import multiplier_slave_pkg::*;

`ifdef MUL_SLAVE_INTR_EN
  localparam bit HAS_INTR = 1'b1;
`else
  localparam bit HAS_INTR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplier_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  logic         o_intr;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  mcand;
  logic [63:0]  mplier;
  logic [1:0]   core_state;
  logic [127:0] core_result;

  multiplier_slave #(.ADDR_W(4), .DATA_W(32), .OPND_W(64)) dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (bus),
    .o_intr       (o_intr),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .core_state   (core_state),
    .core_result  (core_result)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Behavioural core stub: LOAD, a few EXEC cycles, then DONE until cleared/restarted
  logic         core_hold = 1'b0;
  int           core_cnt;
  logic [127:0] core_prod;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_state <= CORE_INIT;
      core_cnt   <= 0;
      core_prod  <= '0;
    end else if (op_clear) begin
      core_state <= CORE_INIT;
    end else if (op_start) begin
      core_state <= CORE_LOAD;
      core_cnt   <= int'($urandom_range(1, 5));
      core_prod  <= smul(mcand, mplier);
    end else begin
      case (core_state)
        CORE_LOAD: core_state <= CORE_EXEC;
        CORE_EXEC: if (!core_hold) begin
          if (core_cnt == 0) core_state <= CORE_DONE;
          else core_cnt <= core_cnt - 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk)
    core_result <= (core_state == CORE_DONE) ? core_prod
                 : {$urandom(), $urandom(), $urandom(), $urandom()};

  int n_start_pulses = 0;
  int n_clear_pulses = 0;
  always @(negedge clk) begin
    if (op_start === 1'b1) n_start_pulses <= n_start_pulses + 1;
    if (op_clear === 1'b1) n_clear_pulses <= n_clear_pulses + 1;
  end

  // Reference model of the programmer-visible state
  logic [63:0]  exp_a;
  logic [63:0]  exp_b;
  logic [127:0] exp_res;
  logic         exp_done;
  logic         exp_busy;
  logic         exp_intr_en;

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus.S_sel  = 1'b1;
    bus.S_wr   = 1'b1;
    bus.S_addr = a;
    bus.S_din  = d;
    @(posedge clk);
    #1;
    bus.S_sel = 1'b0;
    bus.S_wr  = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    bus.S_sel  = 1'b1;
    bus.S_wr   = 1'b0;
    bus.S_addr = a;
    @(posedge clk);
    #1;
    d = bus.S_dout;
    bus.S_sel = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_rd(ADDR_STATUS, d);
    chk(tag, d, {30'd0, exp_done, exp_busy});
  endtask

  task automatic check_intr(input string tag);
    chk(tag, o_intr, HAS_INTR & exp_done & exp_intr_en);
  endtask

  task automatic check_result(input string tag);
    logic [31:0] d;
    for (int w = 0; w < 4; w++) begin
      bus_rd(ADDR_RESULT0 + 4'(w), d);
      chk($sformatf("%s_w%0d", tag, w), d, exp_res[w*32 +: 32]);
    end
  endtask

  task automatic check_operands(input string tag);
    logic [31:0] d;
    bus_rd(ADDR_A_LO, d); chk({tag, "_alo"}, d, exp_a[31:0]);
    bus_rd(ADDR_A_HI, d); chk({tag, "_ahi"}, d, exp_a[63:32]);
    bus_rd(ADDR_B_LO, d); chk({tag, "_blo"}, d, exp_b[31:0]);
    bus_rd(ADDR_B_HI, d); chk({tag, "_bhi"}, d, exp_b[63:32]);
    chk({tag, "_mcand"}, mcand, exp_a);
    chk({tag, "_mplier"}, mplier, exp_b);
  endtask

  task automatic load_operands(input logic [63:0] a, input logic [63:0] b);
    bus_wr(ADDR_A_LO, a[31:0]);
    bus_wr(ADDR_A_HI, a[63:32]);
    bus_wr(ADDR_B_LO, b[31:0]);
    bus_wr(ADDR_B_HI, b[63:32]);
    if (!exp_busy) begin
      exp_a = a;
      exp_b = b;
    end
  endtask

  task automatic issue_start(input string tag);
    int s0;
    s0 = n_start_pulses;
    bus_wr(ADDR_START, 32'h1);
    chk({tag, "_opstart_hi"}, op_start, 1'b1);
    exp_done = 1'b0;
    exp_busy = 1'b1;
    check_intr({tag, "_intr_start"});
    @(posedge clk); #1;
    chk({tag, "_opstart_lo"}, op_start, 1'b0);
    chk({tag, "_npulse"}, 32'(n_start_pulses - s0), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    bit          seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bus_rd(ADDR_STATUS, d);
      if (d[1]) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    exp_done = 1'b1;
    exp_busy = 1'b0;
    exp_res  = smul(exp_a, exp_b);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    load_operands(a, b);
    issue_start(tag);
    wait_done(tag);
    check_intr({tag, "_intr_done"});
    check_status({tag, "_status"});
    check_result({tag, "_res"});
    chk({tag, "_mcand"}, mcand, exp_a);
    chk({tag, "_mplier"}, mplier, exp_b);
    $display("op %s A=%h B=%h P=%h", tag, a, b, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  d;
    logic [127:0] prev_res;
    logic [63:0]  ra;
    logic [63:0]  rb;
    bit           en;
    int           c0;

    bus.S_sel = 1'b0; bus.S_wr = 1'b0; bus.S_addr = '0; bus.S_din = '0;
    exp_a = '0; exp_b = '0; exp_res = '0;
    exp_done = 1'b0; exp_busy = 1'b0; exp_intr_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_dout", bus.S_dout, 32'd0);
    chk("rst_opstart", op_start, 1'b0);
    chk("rst_opclear", op_clear, 1'b0);
    chk("rst_intr", o_intr, 1'b0);
    check_status("rst_status");
    check_operands("rst");
    check_result("rst_res");

    bus_wr(ADDR_INTR_EN, 32'h1);
    exp_intr_en = 1'b1;
    bus_rd(ADDR_INTR_EN, d);
    chk("intr_en_rd", d, {31'd0, HAS_INTR});

    run_op("t1", 64'd7, 64'd6);
    run_op("t2", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);

    for (int k = 0; k < 12; k++) begin
      en = 1'($urandom_range(0, 1));
      bus_wr(ADDR_INTR_EN, {31'd0, en});
      exp_intr_en = en;
      check_intr($sformatf("r%0d_intr_en", k));
      if (k % 3 == 0) begin
        ra = {{32{1'b0}}, $urandom()};
        rb = {{32{1'b1}}, $urandom()};
      end else begin
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
      end
      run_op($sformatf("r%0d", k), ra, rb);
    end

    // Core held in EXEC: operand and START writes must be ignored, RESULT must hold
    prev_res  = exp_res;
    core_hold = 1'b1;
    load_operands(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    issue_start("t3");
    repeat (3) @(posedge clk); #1;
    bus_wr(ADDR_A_LO, 32'h1234);
    bus_rd(ADDR_A_LO, d);
    chk("t3_alo_kept", d, exp_a[31:0]);
    c0 = n_start_pulses;
    bus_wr(ADDR_START, 32'h1);
    repeat (2) @(posedge clk); #1;
    chk("t3_no_restart", 32'(n_start_pulses - c0), 32'd0);
    check_status("t3_status_busy");
    bus_rd(ADDR_RESULT0, d);
    chk("t3_res_hold", d, prev_res[31:0]);
    check_intr("t3_intr");

    c0 = n_clear_pulses;
    bus_wr(ADDR_CLEAR, 32'h1);
    chk("t4_opclear_hi", op_clear, 1'b1);
    exp_done = 1'b0; exp_busy = 1'b0; exp_res = '0;
    @(posedge clk); #1;
    chk("t4_opclear_lo", op_clear, 1'b0);
    chk("t4_nclear", 32'(n_clear_pulses - c0), 32'd1);
    check_status("t4_status");
    check_result("t4_res");
    check_operands("t4");
    check_intr("t4_intr");
    core_hold = 1'b0;
    run_op("t4_rerun", {$urandom(), $urandom()}, {$urandom(), $urandom()});

    bus_wr(ADDR_RESULT0, 32'hDEAD_BEEF);
    bus_wr(ADDR_STATUS, 32'h0);
    check_result("ro_res");
    check_status("ro_status");
    for (int a = 12; a < 16; a++) begin
      bus_rd(4'(a), d);
      chk($sformatf("unmapped_%0h", a), d, 32'd0);
    end

    // Asynchronous reset in the middle of a run
    core_hold = 1'b1;
    load_operands({$urandom(), $urandom()}, {$urandom(), $urandom()});
    issue_start("t6");
    bus_rd(ADDR_STATUS, d);
    chk("t6_busy_before", d, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_dout", bus.S_dout, 32'd0);
    chk("t6_opstart", op_start, 1'b0);
    chk("t6_intr", o_intr, 1'b0);
    chk("t6_mcand", mcand, 64'd0);
    chk("t6_mplier", mplier, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    core_hold = 1'b0;
    exp_a = '0; exp_b = '0; exp_res = '0;
    exp_done = 1'b0; exp_busy = 1'b0; exp_intr_en = 1'b0;
    check_status("t6_status");
    check_result("t6_res");
    bus_rd(ADDR_INTR_EN, d);
    chk("t6_intr_en", d, 32'd0);
    run_op("t6_after", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
